// File: rtl/reg_bank.sv
// Register bank with per-register pending (scoreboard) bits and an issue-stall output.
// Optional RB_WRITE_BYPASS_EN forwards same-cycle write data to reads and drops that operand's stall.
module reg_bank #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        rd_addr_a,
    input  logic [3:0]        rd_addr_b,
    input  logic              rd_use_a,
    input  logic              rd_use_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              resv_en,
    input  logic [3:0]        resv_addr,
    output logic              stall,
    output logic [4:0]        pend_cnt
);
    // Address space is fixed at 16; entries at or above NREGS stay constant zero.
    localparam logic [15:0] VALID = (NREGS >= 16) ? 16'hFFFF : 16'((32'd1 << NREGS) - 32'd1);

    logic [DATA_W-1:0] regs [16];
    logic [15:0]       pend;
    logic [15:0]       pend_nxt;
    logic              inc;
    logic              dec;
    logic              byp_a;
    logic              byp_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (VALID[i] && wr_en && wr_addr == 4'(i)) regs[i] <= wr_data;
        end
    end

    // Reservation is applied after the write clear so it wins on a same-address collision.
    always_comb begin
        pend_nxt = pend;
        if (wr_en)   pend_nxt[wr_addr]   = 1'b0;
        if (resv_en) pend_nxt[resv_addr] = 1'b1;
        pend_nxt = pend_nxt & VALID;
    end

    assign inc = resv_en & VALID[resv_addr] & ~pend[resv_addr];
    assign dec = wr_en & pend[wr_addr] & ~(resv_en && resv_addr == wr_addr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= pend_cnt + 5'(inc) - 5'(dec);
        end
    end

`ifdef RB_WRITE_BYPASS_EN
    assign byp_a = wr_en && (wr_addr == rd_addr_a) && VALID[wr_addr];
    assign byp_b = wr_en && (wr_addr == rd_addr_b) && VALID[wr_addr];
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign rd_data_a = byp_a ? wr_data : regs[rd_addr_a];
    assign rd_data_b = byp_b ? wr_data : regs[rd_addr_b];
    assign stall     = (rd_use_a & pend[rd_addr_a] & ~byp_a) |
                       (rd_use_b & pend[rd_addr_b] & ~byp_b);

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank; expectations follow RB_WRITE_BYPASS_EN when defined.
module tb_reg_bank;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic        rd_use_a = 1'b0, rd_use_b = 1'b0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        resv_en = 1'b0;
    logic [3:0]  resv_addr = '0;
    logic        stall;
    logic [4:0]  pend_cnt;

    int vectors = 0;
    int miscompares = 0;

    reg_bank dut (
        .clk(clk), .reset(reset),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_use_a(rd_use_a), .rd_use_b(rd_use_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .resv_en(resv_en), .resv_addr(resv_addr),
        .stall(stall), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check("rst_cnt", 32'(pend_cnt), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        tick();

        // all addresses read zero, nothing pending
        rd_use_a = 1'b1;
        rd_use_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            rd_addr_b = 4'(15 - i);
            #1;
            check("zero_a", rd_data_a, 32'h0);
            check("zero_b", rd_data_b, 32'h0);
            check("zero_stall", 32'(stall), 32'd0);
        end
        check("zero_cnt", 32'(pend_cnt), 32'd0);
        rd_use_a = 1'b0;
        rd_use_b = 1'b0;

        // write r5, read on both ports
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 1'b0;
        rd_addr_a = 4'd5; rd_addr_b = 4'd5;
        #1;
        check("r5_a", rd_data_a, 32'hDEADBEEF);
        check("r5_b", rd_data_b, 32'hDEADBEEF);

        // reserve r3 then release with a write
        resv_en = 1'b1; resv_addr = 4'd3;
        tick();
        resv_en = 1'b0;
        rd_addr_a = 4'd3; rd_use_a = 1'b0;
        #1;
        check("r3_nouse_stall", 32'(stall), 32'd0);
        rd_use_a = 1'b1;
        #1;
        check("r3_stall", 32'(stall), 32'd1);
        check("r3_cnt1", 32'(pend_cnt), 32'd1);
        rd_use_a = 1'b0; rd_use_b = 1'b1; rd_addr_b = 4'd3;
        #1;
        check("r3_stall_b", 32'(stall), 32'd1);
        rd_use_b = 1'b0; rd_use_a = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h12;
        tick();
        wr_en = 1'b0;
        #1;
        check("r3_rel_stall", 32'(stall), 32'd0);
        check("r3_rel_cnt", 32'(pend_cnt), 32'd0);
        check("r3_rel_data", rd_data_a, 32'h12);

        // re-reserve keeps count; same-cycle write+reserve keeps pend set
        resv_en = 1'b1; resv_addr = 4'd3;
        tick();
        check("rresv_cnt1", 32'(pend_cnt), 32'd1);
        tick();
        check("rresv_cnt2", 32'(pend_cnt), 32'd1);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h7;
        tick();
        wr_en = 1'b0; resv_en = 1'b0;
        #1;
        check("coll_data", rd_data_a, 32'h7);
        check("coll_stall", 32'(stall), 32'd1);
        check("coll_cnt", 32'(pend_cnt), 32'd1);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h7;
        tick();
        wr_en = 1'b0;
        check("coll_clr_cnt", 32'(pend_cnt), 32'd0);

        // write to non-pending register leaves count alone
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h0BADF00D;
        tick();
        wr_en = 1'b0;
        rd_addr_b = 4'd5;
        #1;
        check("np_cnt", 32'(pend_cnt), 32'd0);
        check("np_data", rd_data_b, 32'h0BADF00D);

        // write r6 and reserve r7 together: net zero
        resv_en = 1'b1; resv_addr = 4'd6;
        tick();
        check("r6_cnt", 32'(pend_cnt), 32'd1);
        resv_addr = 4'd7; wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'h66;
        tick();
        resv_en = 1'b0; wr_en = 1'b0;
        rd_addr_a = 4'd7; rd_addr_b = 4'd6; rd_use_b = 1'b0;
        #1;
        check("net0_cnt", 32'(pend_cnt), 32'd1);
        check("net0_stall", 32'(stall), 32'd1);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77;
        tick();
        wr_en = 1'b0;
        check("r7_clr_cnt", 32'(pend_cnt), 32'd0);

        // same-cycle write/read of a pending register
        resv_en = 1'b1; resv_addr = 4'd9;
        tick();
        resv_en = 1'b0;
        rd_addr_a = 4'd9; rd_use_a = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hA5;
        #1;
`ifdef RB_WRITE_BYPASS_EN
        check("byp_data", rd_data_a, 32'hA5);
        check("byp_stall", 32'(stall), 32'd0);
`else
        check("nobyp_data", rd_data_a, 32'h0);
        check("nobyp_stall", 32'(stall), 32'd1);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        check("r9_data", rd_data_a, 32'hA5);
        check("r9_stall", 32'(stall), 32'd0);
        check("r9_cnt", 32'(pend_cnt), 32'd0);

        // reset mid-cycle with pending registers and a write in flight
        resv_en = 1'b1; resv_addr = 4'd1;
        tick();
        resv_addr = 4'd2;
        tick();
        resv_addr = 4'd4;
        tick();
        resv_en = 1'b0;
        check("pre_rst_cnt", 32'(pend_cnt), 32'd3);
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h55;
        rd_addr_a = 4'd1; rd_addr_b = 4'd2; rd_use_a = 1'b1; rd_use_b = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        check("mrst_cnt", 32'(pend_cnt), 32'd0);
        check("mrst_stall", 32'(stall), 32'd0);
        check("mrst_r2", rd_data_b, 32'h0);
`ifndef RB_WRITE_BYPASS_EN
        check("mrst_r1_now", rd_data_a, 32'h0);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        check("mrst_r1", rd_data_a, 32'h0);
        check("mrst_r5", dut.rd_data_b, 32'h0);
        reset = 1'b0;

        // first edge after reset takes write and reservation
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h99;
        resv_en = 1'b1; resv_addr = 4'd4;
        rd_addr_b = 4'd4;
        tick();
        wr_en = 1'b0; resv_en = 1'b0;
        #1;
        check("post_r1", rd_data_a, 32'h99);
        check("post_cnt", 32'(pend_cnt), 32'd1);
        check("post_stall", 32'(stall), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W SHALL default to 32 and set the register and data width.
REQ-003 Parameter NREGS SHALL default to 16 and set the register count; address width is fixed at 4.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 rd_addr_a, rd_addr_b  in  4  read port A/B addresses.
REQ-007 rd_use_a, rd_use_b  in  1  port A/B operand needed by the issuing instruction; qualifies stall.
REQ-008 rd_data_a, rd_data_b  out  DATA_W  read port A/B data.
REQ-009 wr_en  in  1  write strobe.
REQ-010 wr_addr  in  4  destination register, taken from the AR/T destination-select mux.
REQ-011 wr_data  in  DATA_W  write data (ALU result or constant, from the constant-select mux).
REQ-012 resv_en, resv_addr  in  1, 4  reserve the destination of a newly issued instruction.
REQ-013 stall  out  1  issue must hold because an operand is pending.
REQ-014 pend_cnt  out  5  number of registers currently pending.

Function
REQ-015 Storage SHALL be NREGS x DATA_W flops, all writable including register 0.
REQ-016 Reads SHALL be combinational from the current array, with 0-cycle latency.
REQ-017 A write with wr_en=1 SHALL update reg[wr_addr] on the rising edge and clear pend[wr_addr].
REQ-018 resv_en=1 SHALL set pend[resv_addr] on the rising edge; re-reserving an already pending register leaves it set and pend_cnt unchanged.
REQ-019 On simultaneous wr_en and resv_en to the same address, the write SHALL update data and pend SHALL end set (reservation wins).
REQ-020 stall SHALL be combinational: (rd_use_a & pend[rd_addr_a]) | (rd_use_b & pend[rd_addr_b]), subject to REQ-028.
REQ-021 Reservation SHALL be honoured regardless of stall; the issue logic is responsible for not asserting resv_en while stall=1.
REQ-022 pend_cnt SHALL be a registered count equal to popcount(pend) after every edge: +1 on reservation of a clear register, -1 on a write clearing a set register, net 0 when both occur on different addresses.
REQ-023 A write to a non-pending register SHALL update data and leave pend_cnt unchanged.
REQ-024 Both read ports addressing the same register SHALL return identical data.

Reset
REQ-025 Asserting reset SHALL immediately clear all registers to 0, all pend bits to 0, and pend_cnt to 0, with stall=0 while reset is held.
REQ-026 Reset asserted mid-operation SHALL discard any same-cycle write or reservation.
REQ-027 After reset deasserts, the first rising edge SHALL accept writes and reservations normally.

Configuration
REQ-028 With macro RB_WRITE_BYPASS_EN defined, a read whose address equals wr_addr while wr_en=1 SHALL return wr_data, and that operand SHALL NOT contribute to stall in that cycle; without the macro, the read SHALL return the stored value and the pending operand SHALL stall until the edge after the write.

Verification
REQ-029 Reset, then read all 16 addresses on both ports -> every rd_data is 0x00000000, stall=0, pend_cnt=0.
REQ-030 Write 0xDEADBEEF to r5, then read r5 on A and B -> both return 0xDEADBEEF on the next cycle.
REQ-031 Reserve r3; next cycle rd_addr_a=3 with rd_use_a=1 -> stall=1 and pend_cnt=1; write 0x12 to r3 -> stall=0 after the edge and pend_cnt=0.
REQ-032 Same cycle: wr r3=0x7 and resv r3 -> r3 reads 0x7 and pend[3] remains set (stall=1 when r3 is used), pend_cnt unchanged.
REQ-033 Reserve r9, then in one cycle write r9=0xA5 while reading r9 with rd_use_a=1 -> with RB_WRITE_BYPASS_EN: rd_data_a=0xA5 and stall=0; without it: stall=1 that cycle and 0xA5 is returned the cycle after.
REQ-034 Reserve r1, r2, r4, then assert reset mid-cycle together with wr r1 -> pend_cnt=0, r1=0, and stall=0 immediately.
